// File: rtl/adc_spi_responder.sv
// Slave-side model of an 8-channel 12-bit serial ADC, oversampled on iCLK.
// Optional build macro ADC_RESP_TESTPAT_EN: return {next_ch, frame counter} in place of bank data.
module adc_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iCS_n,
    input  logic        iSCLK,
    input  logic        iDIN,
    output logic        oDOUT,
    input  logic        iWR_EN,
    input  logic [2:0]  iWR_CH,
    input  logic [11:0] iWR_DATA,
    output logic [2:0]  oADDR,
    output logic        oFRAME_DONE,
    output logic        oABORT
);

    typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, din_sync;
    logic        cs_d, sclk_d;
    logic        cs_s, sclk_s, din_s;
    logic        cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic        frame_start, frame_done, frame_abort, do_rise, do_fall;
    logic [4:0]  rise_cnt;
    logic [2:0]  addr_cap, next_ch;
    logic [15:0] shreg, snapshot;
    logic [11:0] bank [8];

    // CS_n synchronizer resets to "selected" so a frame already running at
    // reset release cannot produce a false CS_n fall; only a real fall starts.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            cs_sync   <= '0;
            sclk_sync <= '1;
            din_sync  <= '0;
            cs_d      <= 1'b0;
            sclk_d    <= 1'b1;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], iCS_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], iSCLK};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], iDIN};
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // TAIL: rise 16 seen; rises ignored, falls keep shifting zeros out.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        frame_abort = 1'b0;
        do_rise     = 1'b0;
        do_fall     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    frame_start = 1'b1;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                do_rise = sclk_rise;
                do_fall = sclk_fall & ~cs_rise;
                if (sclk_rise && rise_cnt == 5'd15) begin
                    frame_done = 1'b1;
                    state_d    = cs_rise ? IDLE : TAIL;
                end else if (cs_rise) begin
                    frame_abort = 1'b1;
                    state_d     = IDLE;
                end
            end
            TAIL: begin
                do_fall = sclk_fall & ~cs_rise;
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ADC_RESP_TESTPAT_EN
    logic [8:0] frame_cnt;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n)         frame_cnt <= '0;
        else if (frame_done) frame_cnt <= frame_cnt + 9'd1;
    end

    assign snapshot = {4'b0, next_ch, frame_cnt};
`else
    assign snapshot = {4'b0, bank[next_ch]};
`endif

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            rise_cnt    <= '0;
            addr_cap    <= '0;
            next_ch     <= '0;
            oADDR       <= '0;
            shreg       <= '0;
            oDOUT       <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oABORT      <= 1'b0;
        end else begin
            oFRAME_DONE <= frame_done;
            oABORT      <= frame_abort;
            if (frame_start) begin
                rise_cnt <= '0;
                shreg    <= snapshot;
                oDOUT    <= snapshot[15];
            end else begin
                if (do_rise) begin
                    if (rise_cnt != 5'd16) rise_cnt <= rise_cnt + 5'd1;
                    case (rise_cnt)
                        5'd2:    addr_cap[2] <= din_s;
                        5'd3:    addr_cap[1] <= din_s;
                        5'd4:    addr_cap[0] <= din_s;
                        default: ;
                    endcase
                end
                if (do_fall) begin
                    shreg <= {shreg[14:0], 1'b0};
                    oDOUT <= shreg[14];
                end
                if (cs_rise) oDOUT <= 1'b0;
            end
            if (frame_done) begin
                next_ch <= addr_cap;
                oADDR   <= addr_cap;
            end
        end
    end

    // Bank read for the snapshot sees the pre-write value in a colliding cycle.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int i = 0; i < 8; i++) bank[i] <= '0;
        end else if (iWR_EN) begin
            bank[iWR_CH] <= iWR_DATA;
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: acts as the SPI controller, keeps a frame-level
// model of bank/next channel, and checks outputs every cycle against it.
module tb_adc_spi_responder;

    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 1;
    localparam int T    = SYNC + 3;

    logic        iCLK = 1'b0;
    logic        iRST_n = 1'b1;
    logic        iCS_n = 1'b1;
    logic        iSCLK = 1'b1;
    logic        iDIN = 1'b0;
    logic        iWR_EN = 1'b0;
    logic [2:0]  iWR_CH = '0;
    logic [11:0] iWR_DATA = '0;
    logic        oDOUT;
    logic [2:0]  oADDR;
    logic        oFRAME_DONE;
    logic        oABORT;

    adc_spi_responder #(.SYNC_STAGES(SYNC)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iCS_n(iCS_n), .iSCLK(iSCLK), .iDIN(iDIN),
        .oDOUT(oDOUT), .iWR_EN(iWR_EN), .iWR_CH(iWR_CH), .iWR_DATA(iWR_DATA),
        .oADDR(oADDR), .oFRAME_DONE(oFRAME_DONE), .oABORT(oABORT)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Expected-event schedule published by the driver, consumed by the compare process.
    int         done_at  = -100;
    int         abort_at = -100;
    logic [2:0] done_addr = '0;
    logic [2:0] addr_m = '0;
    bit         chk_dout = 1'b0;
    bit         exp_dout = 1'b0;

    // Frame-level model state.
    logic [11:0] bank_m [8];
    logic [2:0]  next_m = '0;
    logic [8:0]  cnt_m = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge iCLK) begin
        if (!iRST_n) begin
            addr_m = '0;
            check("rst_dout", oDOUT, 0);
            check("rst_addr", oADDR, 0);
            check("rst_done", oFRAME_DONE, 0);
            check("rst_abort", oABORT, 0);
        end else begin
            if (cyc == done_at) addr_m = done_addr;
            check("frame_done", oFRAME_DONE, cyc == done_at);
            check("abort", oABORT, cyc == abort_at);
            check("addr", oADDR, addr_m);
            if (chk_dout) check("dout", oDOUT, exp_dout);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) bank_m[i] = '0;
        next_m = '0;
        cnt_m  = '0;
    endtask

    task automatic bank_write(input logic [2:0] ch, input logic [11:0] data);
        iWR_EN = 1'b1; iWR_CH = ch; iWR_DATA = data;
        tick(1);
        iWR_EN = 1'b0;
        bank_m[ch] = data;
    endtask

    function automatic logic [15:0] model_word();
`ifdef ADC_RESP_TESTPAT_EN
        return {4'b0, next_m, cnt_m};
`else
        return {4'b0, bank_m[next_m]};
`endif
    endfunction

    function automatic logic din_for(input logic [2:0] a, input int i);
        case (i)
            3:       return a[2];
            4:       return a[1];
            5:       return a[0];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // One controller frame: SCLK drops together with CS_n, then nr rise/fall pairs.
    task automatic do_frame(input logic [2:0] addr, input int nr, input bit simul,
                            input bit wr_start, input logic [11:0] wr_data,
                            input bit rst_end, output logic [15:0] rx);
        logic [15:0] w;
        w  = model_word();
        rx = '0;
        iCS_n = 1'b0; iSCLK = 1'b0; iDIN = din_for(addr, 1);
        if (wr_start) begin
            tick(LAT - 1);
            bank_write(next_m, wr_data);
            tick(T - LAT);
        end else begin
            tick(T);
        end
        for (int i = 1; i <= nr; i++) begin
            if (i > 1) begin
                chk_dout = 1'b0;
                iSCLK = 1'b0; iDIN = din_for(addr, i);
                tick(T);
            end
            iSCLK = 1'b1;
            rx = {rx[14:0], oDOUT};
            exp_dout = w[16-i];
            chk_dout = 1'b1;
            if (i == 16) begin
                done_at = cyc + LAT;
                done_addr = addr;
                if (simul) begin
                    iCS_n = 1'b1;
                    chk_dout = 1'b0;
                end
            end
            tick(T);
        end
        if (rst_end) begin
            exp_dout = 1'b0; chk_dout = 1'b1;
            iRST_n = 1'b0;
            done_at = -100; abort_at = -100;
            model_reset();
            return;
        end
        if (!simul) begin
            chk_dout = 1'b0;
            if (nr < 16) abort_at = cyc + LAT;
            iCS_n = 1'b1; iSCLK = 1'b1;
        end
        tick(LAT + 1);
        exp_dout = 1'b0; chk_dout = 1'b1;
        tick(T);
        if (nr == 16) begin
            next_m = addr;
            cnt_m++;
        end
        if (nr > 0) check("rx_word", rx, w >> (16 - nr));
    endtask

    logic [15:0] rx;

    initial begin
        model_reset();
        #2 iRST_n = 1'b0;
        tick(3);
        check("reset_dout", oDOUT, 0);
        check("reset_addr", oADDR, 0);
        iRST_n = 1'b1;
        exp_dout = 1'b0; chk_dout = 1'b1;
        tick(4);

`ifndef ADC_RESP_TESTPAT_EN
        bank_write(3'd5, 12'hA5C);
        do_frame(3'd5, 16, 0, 0, '0, 0, rx);
        check("t1_first_word", rx, 16'h0000);
        do_frame(3'd5, 16, 0, 0, '0, 0, rx);
        check("t1_second_word", rx, 16'h0A5C);
        check("t1_addr", oADDR, 3'd5);

        do_frame(3'd3, 8, 0, 0, '0, 0, rx);
        check("abort_addr_kept", oADDR, 3'd5);
        bank_write(3'd0, 12'hFFF);
        do_frame(3'd0, 16, 0, 0, '0, 0, rx);
        check("abort_prev_channel", rx, 16'h0A5C);
        do_frame(3'd0, 16, 0, 0, '0, 0, rx);
        check("fff_word", rx, 16'h0FFF);

        bank_write(3'd0, 12'h456);
        do_frame(3'd0, 16, 0, 1, 12'h123, 0, rx);
        check("snap_old_value", rx, 16'h0456);
        do_frame(3'd2, 16, 1, 0, '0, 0, rx);
        check("snap_new_value", rx, 16'h0123);
        check("simul_end_addr", oADDR, 3'd2);

        do_frame(3'd6, 10, 0, 0, '0, 1, rx);
        tick(3);
        check("midrst_dout", oDOUT, 0);
        check("midrst_addr", oADDR, 0);
        iRST_n = 1'b1;
        repeat (4) begin
            iSCLK = 1'b0; tick(T);
            iSCLK = 1'b1; tick(T);
        end
        iCS_n = 1'b1;
        tick(LAT + T);
        do_frame(3'd6, 16, 0, 0, '0, 0, rx);
        check("post_rst_word", rx, 16'h0000);
        check("post_rst_addr", oADDR, 3'd6);
`else
        do_frame(3'd2, 16, 0, 0, '0, 0, rx);
        check("tp_word0", rx, 16'h0000);
        do_frame(3'd2, 16, 0, 0, '0, 0, rx);
        check("tp_word1", rx, 16'h0401);
        do_frame(3'd2, 16, 0, 0, '0, 0, rx);
        check("tp_word2", rx, 16'h0402);
`endif

        for (int k = 0; k < 40; k++) begin
            logic [2:0]  a;
            int          nr;
            bit          sim;
            bit          ws;
            a = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                bank_write(3'($urandom_range(0, 7)), 12'($urandom));
            nr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 16;
            sim = (nr == 16) && ($urandom_range(0, 3) == 0);
            ws  = ($urandom_range(0, 7) == 0);
            do_frame(a, nr, sim, ws, 12'($urandom), 0, rx);
        end

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
